writeback_stage: RTL
====================

WRITEBACK_STAGE -- requirements
Module: writeback_stage

Interface
REQ-001 Parameter COUNT_W, default 16: width of the retired-instruction counter.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  reset, synchronous, active-high.
REQ-004 valid_in  input  1  execute result presented this cycle.
REQ-005 ready_out  output  1  stage can accept; high only in IDLE.
REQ-006 opcode  input  5  opcode of the presented instruction.
REQ-007 rd  input  3  destination register index.
REQ-008 mem_addr  input  4  data-memory address for store.
REQ-009 result  input  16  execute result; [15:8] meaningful only for mul/div.
REQ-010 zero_in, carry_in, ac_in, parity_in  input  1 each  execute flags.
REQ-011 rf_we  output  1  register-file write strobe.
REQ-012 rf_waddr  output  3  register-file write index.
REQ-013 rf_wdata  output  8  register-file write data.
REQ-014 mem_we  output  1  data-memory write strobe.
REQ-015 mem_waddr  output  4  data-memory write address.
REQ-016 mem_wdata  output  8  data-memory write data.
REQ-017 flags_q  output  4  architectural flags {zero,carry,ac,parity}.
REQ-018 halted  output  1  sticky halt indicator.
REQ-019 instr_count  output  COUNT_W  retired-instruction count.

Function
REQ-020 States IDLE, WRITE_HI, HALTED; accept = valid_in && ready_out.
REQ-021 All write outputs are registered; strobes appear the cycle after acceptance, one-cycle pulses; no combinational input-to-output path.
REQ-022 Single-write class (00000-00010, 00101-01011, 10000-10101): rf_we=1, rf_waddr=rd, rf_wdata=result[7:0].
REQ-023 Mul/div (00011, 00100): first cycle writes rd <- result[7:0], state -> WRITE_HI; next cycle writes (rd+1) mod 8 <- result[15:8] (rd=7 wraps to 0), state -> IDLE; ready_out low throughout WRITE_HI.
REQ-024 Result[15:8] and rd are latched at acceptance; input changes during WRITE_HI have no effect.
REQ-025 Store (01100): mem_we=1, mem_waddr=mem_addr, mem_wdata=result[7:0]; no register write.
REQ-026 Compare (11001): no register or memory write; flags updated.
REQ-027 Jump/branch (01101, 01110, 10110, 10111, 11000): no write, flags unchanged.
REQ-028 Flags are captured from *_in at acceptance for single-write, mul/div and compare classes; load (01011), store, jump, branch and unlisted opcodes leave flags_q unchanged.
REQ-029 Halt (11111): no write, state -> HALTED, halted=1; ready_out stays 0 until reset.
REQ-030 Unlisted opcodes (01111, 11010-11110): retired as no-ops.
REQ-031 instr_count increments by 1 on every acceptance, including halt; wraps from all-ones to 0.
REQ-032 valid_in while ready_out=0 is ignored; the producer holds it.
REQ-033 Writes to register 0 are legal; there is no hardwired zero register.

Reset
REQ-034 When reset is high at a clock edge: state IDLE, all strobes 0, addresses/data 0, flags_q 0, halted 0, instr_count 0.
REQ-035 Reset takes priority over acceptance; reset during WRITE_HI aborts the pending high-byte write.

Structure
REQ-036 Shared package isa_pkg holds the 5-bit opcode constants, flag bit indices, and the state enumeration.
REQ-037 One combinational sub-module wb_decode maps opcode to class flags {reg_wr, dual_wr, mem_wr, flag_upd, halt}.

Verification
REQ-038 Reset, then ADD rd=3 result=0x0045 flags 0100 -> next cycle rf_we=1 waddr=3 wdata=0x45; flags_q=0100; instr_count=1.
REQ-039 MUL rd=7 result=0x1234 -> cycle1 write r7=0x34, cycle2 write r0=0x12, ready_out low for exactly 1 cycle.
REQ-040 STORE mem_addr=0xA result=0x00FF after ADD set flags 1000 -> mem_we=1 addr 0xA data 0xFF; rf_we=0; flags_q stays 1000.
REQ-041 HALT, then ADD held valid 10 cycles -> halted=1, ready_out=0, no strobes, instr_count unchanged; reset clears all.
REQ-042 DIV rd=2 accepted, reset asserted in WRITE_HI -> no r3 write; all outputs 0 next cycle.
REQ-043 Preload instr_count by 0xFFFF acceptances, one more NOP -> instr_count=0.

Source files
------------

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcode constants, flag indices and writeback state encoding
package isa_pkg;

    localparam logic [4:0] OP_ADD   = 5'b00000;
    localparam logic [4:0] OP_MUL   = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_LOAD  = 5'b01011;
    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_JMP   = 5'b01101;
    localparam logic [4:0] OP_NOP   = 5'b01111;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    // Bit positions inside the architectural flags word {zero,carry,ac,parity}
    localparam int FLAG_ZERO   = 3;
    localparam int FLAG_CARRY  = 2;
    localparam int FLAG_AC     = 1;
    localparam int FLAG_PARITY = 0;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE_HI = 2'd1,
        ST_HALTED   = 2'd2
    } wb_state_e;

    typedef struct packed {
        logic reg_wr;
        logic dual_wr;
        logic mem_wr;
        logic flag_upd;
        logic halt;
    } wb_class_t;

endpackage

// File: rtl/wb_decode.sv
// rtl/wb_decode.sv - opcode to writeback class decoder (combinational)
module wb_decode
    import isa_pkg::*;
(
    input  logic [4:0] opcode,
    output wb_class_t  cls
);

    always_comb begin
        cls = '0;
        case (opcode) inside
            5'b00000, 5'b00001, 5'b00010,
            [5'b00101:5'b01010],
            [5'b10000:5'b10101]: begin
                cls.reg_wr   = 1'b1;
                cls.flag_upd = 1'b1;
            end
            OP_LOAD: cls.reg_wr = 1'b1;
            OP_MUL, OP_DIV: begin
                cls.reg_wr   = 1'b1;
                cls.dual_wr  = 1'b1;
                cls.flag_upd = 1'b1;
            end
            OP_STORE: cls.mem_wr   = 1'b1;
            OP_CMP:   cls.flag_upd = 1'b1;
            OP_HALT:  cls.halt     = 1'b1;
            // jumps, branches and unlisted opcodes retire with no side effect
            default:  cls = '0;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// rtl/writeback_stage.sv - registered writeback stage with dual-write mul/div and halt
module writeback_stage
    import isa_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic [4:0]         opcode,
    input  logic [2:0]         rd,
    input  logic [3:0]         mem_addr,
    input  logic [15:0]        result,
    input  logic               zero_in,
    input  logic               carry_in,
    input  logic               ac_in,
    input  logic               parity_in,
    output logic               rf_we,
    output logic [2:0]         rf_waddr,
    output logic [7:0]         rf_wdata,
    output logic               mem_we,
    output logic [3:0]         mem_waddr,
    output logic [7:0]         mem_wdata,
    output logic [3:0]         flags_q,
    output logic               halted,
    output logic [COUNT_W-1:0] instr_count
);

    wb_state_e state_q, state_d;
    wb_class_t cls;
    logic      accept;

    logic               rf_we_q, rf_we_d;
    logic [2:0]         rf_waddr_q, rf_waddr_d;
    logic [7:0]         rf_wdata_q, rf_wdata_d;
    logic               mem_we_q, mem_we_d;
    logic [3:0]         mem_waddr_q, mem_waddr_d;
    logic [7:0]         mem_wdata_q, mem_wdata_d;
    logic [3:0]         flags_d;
    logic               halted_q, halted_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [2:0]         hi_rd_q, hi_rd_d;
    logic [7:0]         hi_byte_q, hi_byte_d;

    wb_decode u_decode (
        .opcode (opcode),
        .cls    (cls)
    );

    assign ready_out = (state_q == ST_IDLE);
    assign accept    = valid_in && ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            rf_we_q     <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            flags_q     <= '0;
            halted_q    <= 1'b0;
            count_q     <= '0;
            hi_rd_q     <= '0;
            hi_byte_q   <= '0;
        end else begin
            state_q     <= state_d;
            rf_we_q     <= rf_we_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_waddr_q <= mem_waddr_d;
            mem_wdata_q <= mem_wdata_d;
            flags_q     <= flags_d;
            halted_q    <= halted_d;
            count_q     <= count_d;
            hi_rd_q     <= hi_rd_d;
            hi_byte_q   <= hi_byte_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (cls.halt)         state_d = ST_HALTED;
                    else if (cls.dual_wr) state_d = ST_WRITE_HI;
                end
            end
            ST_WRITE_HI: state_d = ST_IDLE;
            ST_HALTED:   state_d = ST_HALTED;
            default:     state_d = ST_IDLE;
        endcase
    end

    // Address/data hold their last value between strobes; only the strobes pulse.
    always_comb begin
        rf_we_d     = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;
        mem_we_d    = 1'b0;
        mem_waddr_d = mem_waddr_q;
        mem_wdata_d = mem_wdata_q;
        flags_d     = flags_q;
        halted_d    = halted_q;
        count_d     = count_q;
        hi_rd_d     = hi_rd_q;
        hi_byte_d   = hi_byte_q;
        if (state_q == ST_WRITE_HI) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = hi_rd_q;
            rf_wdata_d = hi_byte_q;
        end else if (accept) begin
            count_d = count_q + {{(COUNT_W-1){1'b0}}, 1'b1};
            if (cls.reg_wr) begin
                rf_we_d    = 1'b1;
                rf_waddr_d = rd;
                rf_wdata_d = result[7:0];
            end
            if (cls.dual_wr) begin
                hi_rd_d   = rd + 3'd1;
                hi_byte_d = result[15:8];
            end
            if (cls.mem_wr) begin
                mem_we_d    = 1'b1;
                mem_waddr_d = mem_addr;
                mem_wdata_d = result[7:0];
            end
            if (cls.flag_upd) begin
                flags_d[FLAG_ZERO]   = zero_in;
                flags_d[FLAG_CARRY]  = carry_in;
                flags_d[FLAG_AC]     = ac_in;
                flags_d[FLAG_PARITY] = parity_in;
            end
            if (cls.halt) halted_d = 1'b1;
        end
    end

    assign rf_we       = rf_we_q;
    assign rf_waddr    = rf_waddr_q;
    assign rf_wdata    = rf_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_waddr   = mem_waddr_q;
    assign mem_wdata   = mem_wdata_q;
    assign halted      = halted_q;
    assign instr_count = count_q;

endmodule
